// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the rhythm-game note scheduler: FSM encoding,
// default timing, song patterns and small helpers.
package note_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] DEF_STEP_CYC = 16'd50000;
  localparam logic [15:0] DEF_HIT_WIN  = 16'd25000;
  localparam logic [6:0]  DEF_SONG_LEN = 7'd32;

  // Songs are 8-step phrases repeated up to ROM_STEPS; step 0 sits in the LSB byte.
  localparam logic [5:0]  ROM_STEPS = 6'd32;
  localparam logic [63:0] SONG0_PAT = 64'h2018_0004_8006_0001;
  localparam logic [63:0] SONG1_PAT = 64'h8040_2010_0804_0201;
  localparam logic [63:0] SONG2_PAT = 64'h0081_0042_0024_0018;
  localparam logic [63:0] SONG3_PAT = 64'hC300_3C00_0F00_F000;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest set lane wins so chords sound their leftmost note.
  function automatic logic [2:0] lowest_lane(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/note_scheduler_rom.sv
// Song pattern lookup: lane mask for a (song, step) pair; unlisted addresses read 0.
module note_rom
  import note_scheduler_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [5:0] step,
  output logic [7:0] mask
);

  logic [63:0] pat;

  always_comb begin
    case (sel)
      3'd0:    pat = SONG0_PAT;
      3'd1:    pat = SONG1_PAT;
      3'd2:    pat = SONG2_PAT;
      3'd3:    pat = SONG3_PAT;
      default: pat = 64'h0;
    endcase
    mask = (step < ROM_STEPS) ? pat[{step[2:0], 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: rtl/note_scheduler.sv
// Rhythm-game sequencer: steps a song pattern onto the lane LEDs and piezo,
// judges key presses per step, and keeps saturating score and combo counts.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter logic [15:0] STEP_CYC = DEF_STEP_CYC,
  parameter logic [15:0] HIT_WIN  = DEF_HIT_WIN,
  parameter logic [6:0]  SONG_LEN = DEF_SONG_LEN
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       start,
  input  logic       back,
  input  logic [2:0] sel,
  input  logic [7:0] key,
  output logic [7:0] led,
  output logic       tone_req,
  output logic [2:0] tone_sel,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [7:0] combo,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] CNT_LAST  = STEP_CYC - 16'd1;
  localparam logic [6:0]  STEP_LAST = SONG_LEN - 7'd1;

  state_e      state_q, state_d;
  logic        start_p_q, back_p_q;
  logic [7:0]  key_p_q;
  logic [2:0]  sel_q, sel_d;
  logic [5:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pressed_q, pressed_d;
  logic        judged_q, judged_d;
  logic [7:0]  score_q, score_d, combo_q, combo_d;
  logic [7:0]  led_q, led_d;
  logic        tone_req_q, tone_req_d;
  logic [2:0]  tone_sel_q, tone_sel_d;
  logic        hit_q, hit_d, miss_q, miss_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        start_r, back_r;
  logic [7:0]  key_r, key_in, key_out, rom_mask;
  logic        win_open, step_end, last_step, judgeable, wrong, complete;
  logic        is_hit, is_miss;

  assign start_r = start & ~start_p_q;
  assign back_r  = back & ~back_p_q;
  assign key_r   = key & ~key_p_q;

  // led_q always carries the mask of the step being played while in SHOW.
  assign key_in    = key_r & led_q;
  assign key_out   = key_r & ~led_q;
  assign win_open  = cnt_q < HIT_WIN;
  assign step_end  = cnt_q == CNT_LAST;
  assign last_step = {1'b0, step_q} == STEP_LAST;
  assign judgeable = (state_q == ST_SHOW) && (led_q != 8'h00) && !judged_q && !back_r;
  assign wrong     = win_open && (key_out != 8'h00);
  assign complete  = win_open && ((pressed_q | key_in) == led_q);
  assign is_miss   = judgeable && (wrong || (step_end && !complete));
  assign is_hit    = judgeable && complete && !wrong;

  note_rom u_rom (
    .sel  (sel_d),
    .step (step_d),
    .mask (rom_mask)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    judged_d  = judged_q | is_hit | is_miss;
    score_d   = score_q;
    combo_d   = combo_q;
    hit_d     = is_hit;
    miss_d    = is_miss;

    if (is_hit) begin
      score_d = sat_inc(score_q);
      combo_d = sat_inc(combo_q);
    end else if (is_miss) begin
      combo_d = 8'h00;
    end

    if (back_r) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Clear on entry so LOAD already shows a fresh score.
          if (start_r) begin
            state_d = ST_LOAD;
            score_d = 8'h00;
            combo_d = 8'h00;
          end
        end
        ST_LOAD: begin
          sel_d     = sel;
          score_d   = 8'h00;
          combo_d   = 8'h00;
          step_d    = 6'd0;
          cnt_d     = 16'd0;
          pressed_d = 8'h00;
          judged_d  = 1'b0;
          state_d   = ST_SHOW;
        end
        ST_SHOW: begin
          if (win_open) pressed_d = pressed_q | key_in;
          if (step_end) begin
            cnt_d     = 16'd0;
            pressed_d = 8'h00;
            judged_d  = 1'b0;
            if (last_step) state_d = ST_DONE;
            else           step_d  = step_q + 6'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    led_d      = (state_d == ST_SHOW) ? rom_mask : 8'h00;
    tone_req_d = (state_d == ST_SHOW) && (cnt_d < HIT_WIN) && (led_d != 8'h00);
    tone_sel_d = lowest_lane(led_d);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHOW);
    done_d     = state_d == ST_DONE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_IDLE;
      start_p_q  <= 1'b0;
      back_p_q   <= 1'b0;
      key_p_q    <= 8'h00;
      sel_q      <= 3'd0;
      step_q     <= 6'd0;
      cnt_q      <= 16'd0;
      pressed_q  <= 8'h00;
      judged_q   <= 1'b0;
      score_q    <= 8'h00;
      combo_q    <= 8'h00;
      led_q      <= 8'h00;
      tone_req_q <= 1'b0;
      tone_sel_q <= 3'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_p_q  <= start;
      back_p_q   <= back;
      key_p_q    <= key;
      sel_q      <= sel_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      judged_q   <= judged_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      led_q      <= led_d;
      tone_req_q <= tone_req_d;
      tone_sel_q <= tone_sel_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign led        = led_q;
  assign tone_req   = tone_req_q;
  assign tone_sel   = tone_sel_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler with an 8-cycle step, 4-cycle window, 4-step song.
module tb_note_scheduler;

  logic       CLK, RESETN, start, back;
  logic [2:0] sel;
  logic [7:0] key;
  logic [7:0] led, score, combo;
  logic       tone_req, hit_pulse, miss_pulse, busy, done;
  logic [2:0] tone_sel;

  typedef struct {
    logic       is_hit;
    logic [7:0] score;
    logic [7:0] combo;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0, bad = 0, cyc_cnt = 0, pos = 0;
  logic [7:0] exp_score = 8'h00, exp_combo = 8'h00;

  note_scheduler #(.STEP_CYC(16'd8), .HIT_WIN(16'd4), .SONG_LEN(7'd4)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .back(back), .sel(sel), .key(key),
    .led(led), .tone_req(tone_req), .tone_sel(tone_sel), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score(score), .combo(combo), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n cycles; after each edge any judgement pulse is popped against the scoreboard.
  task automatic cyc(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      cyc_cnt++;
      if (hit_pulse || miss_pulse) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pulse_unexpected: got hit=%0b miss=%0b at cycle %0d, expected none",
                   hit_pulse, miss_pulse, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if (hit_pulse !== e.is_hit || miss_pulse !== !e.is_hit || score !== e.score ||
              combo !== e.combo || cyc_cnt != e.due) begin
            bad++;
            $display("FAIL pulse_match: got hit=%0b miss=%0b score=%0d combo=%0d cyc=%0d, want hit=%0b score=%0d combo=%0d cyc=%0d",
                     hit_pulse, miss_pulse, score, combo, cyc_cnt, e.is_hit, e.score, e.combo, e.due);
          end
        end
      end
    end
  endtask

  task automatic expect_pulse(input logic is_hit);
    exp_t e;
    if (is_hit) begin
      exp_score = (exp_score == 8'hFF) ? exp_score : exp_score + 8'd1;
      exp_combo = (exp_combo == 8'hFF) ? exp_combo : exp_combo + 8'd1;
    end else begin
      exp_combo = 8'h00;
    end
    e.is_hit = is_hit; e.score = exp_score; e.combo = exp_combo; e.due = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic goto_pos(input int p);
    cyc(p - pos);
    pos = p;
  endtask

  task automatic press(input logic [7:0] k);
    key = k;
    cyc(1);
    key = 8'h00;
    pos++;
  endtask

  task automatic start_song();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    pos = 0;
    exp_score = 8'h00;
    exp_combo = 8'h00;
  endtask

  task automatic test_reset();
    logic idle_bad;
    RESETN = 1'b0; start = 1'b0; back = 1'b0; sel = 3'd0; key = 8'h00;
    cyc(3);
    total++;
    if ({led, tone_req, tone_sel, hit_pulse, miss_pulse, score, combo, busy, done} !== 39'h0) begin
      bad++;
      $display("FAIL reset_outputs: led=%h tone=%0b sel=%0d score=%0d combo=%0d busy=%0b done=%0b, want all 0",
               led, tone_req, tone_sel, score, combo, busy, done);
    end
    RESETN = 1'b1;
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (busy !== 1'b0 || led !== 8'h00 || done !== 1'b0) idle_bad = 1'b1;
    end
    total++;
    if (idle_bad !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: busy/led/done left 0 during 100 idle cycles, now busy=%0b led=%h", busy, led);
    end
  endtask

  task automatic test_first_hit();
    sel = 3'd0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || led !== 8'h00 || score !== 8'h00) begin
      bad++;
      $display("FAIL load_cycle: busy=%0b led=%h score=%0d, want busy=1 led=00 score=0", busy, led, score);
    end
    cyc(1);
    pos = 0; exp_score = 8'h00; exp_combo = 8'h00;
    total++;
    if (led !== 8'h01 || tone_req !== 1'b1 || tone_sel !== 3'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL step0_show: led=%h tone=%0b tsel=%0d busy=%0b, want 01 1 0 1", led, tone_req, tone_sel, busy);
    end
    goto_pos(1);
    expect_pulse(1'b1);
    press(8'h01);
    total++;
    if (score !== 8'd1 || combo !== 8'd1) begin
      bad++;
      $display("FAIL first_hit_score: score=%0d combo=%0d, want 1 1", score, combo);
    end
    goto_pos(9);
    total++;
    if (led !== 8'h00 || tone_req !== 1'b0) begin
      bad++;
      $display("FAIL rest_step: led=%h tone=%0b, want 00 0", led, tone_req);
    end
    back = 1'b1;
    cyc(1);
    back = 1'b0;
    pos++;
    total++;
    if (busy !== 1'b0 || led !== 8'h00 || score !== 8'd1) begin
      bad++;
      $display("FAIL back_rest: busy=%0b led=%h score=%0d, want 0 00 1", busy, led, score);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL first_hit_pending: %0d pulses never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_chord_hit();
    start_song();
    goto_pos(1);
    expect_pulse(1'b1);
    press(8'h01);
    goto_pos(16);
    press(8'h02);
    goto_pos(19);
    total++;
    if (led !== 8'h06 || tone_req !== 1'b1 || tone_sel !== 3'd1) begin
      bad++;
      $display("FAIL chord_show: led=%h tone=%0b tsel=%0d, want 06 1 1", led, tone_req, tone_sel);
    end
    expect_pulse(1'b1);
    press(8'h04);
    total++;
    if (tone_req !== 1'b0 || led !== 8'h06) begin
      bad++;
      $display("FAIL window_close: tone=%0b led=%h at cnt 4, want 0 06", tone_req, led);
    end
    goto_pos(24);
    total++;
    if (led !== 8'h80 || tone_sel !== 3'd7) begin
      bad++;
      $display("FAIL step3_show: led=%h tsel=%0d, want 80 7", led, tone_sel);
    end
    goto_pos(26);
    expect_pulse(1'b1);
    press(8'h80);
    goto_pos(31);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL before_done: done=%0b busy=%0b, want 0 1", done, busy);
    end
    goto_pos(32);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || led !== 8'h00 || score !== 8'd3 || combo !== 8'd3) begin
      bad++;
      $display("FAIL song_done: done=%0b busy=%0b led=%h score=%0d combo=%0d, want 1 0 00 3 3",
               done, busy, led, score, combo);
    end
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || score !== 8'd0 || combo !== 8'd0) begin
      bad++;
      $display("FAIL restart_load: busy=%0b done=%0b score=%0d combo=%0d, want 1 0 0 0", busy, done, score, combo);
    end
    cyc(1);
    pos = 0; exp_score = 8'h00; exp_combo = 8'h00;
    back = 1'b1;
    cyc(1);
    back = 1'b0;
    pos++;
    total++;
    if (busy !== 1'b0 || led !== 8'h00) begin
      bad++;
      $display("FAIL back_step0: busy=%0b led=%h, want 0 00", busy, led);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL chord_pending: %0d pulses never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_chord_late();
    start_song();
    goto_pos(1);
    expect_pulse(1'b1);
    press(8'h01);
    goto_pos(16);
    press(8'h02);
    goto_pos(20);
    press(8'h04);
    goto_pos(23);
    expect_pulse(1'b0);
    cyc(1);
    pos = 24;
    total++;
    if (combo !== 8'd0 || score !== 8'd1) begin
      bad++;
      $display("FAIL late_miss: score=%0d combo=%0d, want 1 0", score, combo);
    end
    goto_pos(31);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL late_pre_done: done=%0b, want 0", done);
    end
    expect_pulse(1'b0);
    goto_pos(32);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL last_miss_done: done=%0b busy=%0b with final miss, want 1 0", done, busy);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL late_pending: %0d pulses never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrong_key();
    logic rest_bad;
    start_song();
    goto_pos(1);
    expect_pulse(1'b0);
    press(8'h20);
    press(8'h01);
    rest_bad = 1'b0;
    for (int p = 8; p < 16; p++) begin
      goto_pos(p);
      if (tone_req !== 1'b0 || led !== 8'h00) rest_bad = 1'b1;
      key = (p == 9) ? 8'h01 : (p == 11) ? 8'h80 : 8'h00;
    end
    goto_pos(16);
    total++;
    if (rest_bad !== 1'b0) begin
      bad++;
      $display("FAIL rest_tone: tone_req/led nonzero during rest step, flag=%0b want 0", rest_bad);
    end
    back = 1'b1;
    cyc(1);
    back = 1'b0;
    pos++;
    total++;
    if (busy !== 1'b0 || score !== 8'd0 || combo !== 8'd0) begin
      bad++;
      $display("FAIL wrong_key_end: busy=%0b score=%0d combo=%0d, want 0 0 0", busy, score, combo);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrong_pending: %0d pulses never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back();
    start_song();
    goto_pos(1);
    expect_pulse(1'b1);
    press(8'h01);
    goto_pos(18);
    total++;
    if (led !== 8'h06 || tone_req !== 1'b1) begin
      bad++;
      $display("FAIL back_pre: led=%h tone=%0b, want 06 1", led, tone_req);
    end
    back = 1'b1;
    cyc(1);
    back = 1'b0;
    pos++;
    total++;
    if (busy !== 1'b0 || led !== 8'h00 || tone_req !== 1'b0 || score !== 8'd1 || combo !== 8'd1) begin
      bad++;
      $display("FAIL back_mid: busy=%0b led=%h tone=%0b score=%0d combo=%0d, want 0 00 0 1 1",
               busy, led, tone_req, score, combo);
    end
    cyc(3);
    start = 1'b1;
    back  = 1'b1;
    cyc(1);
    total++;
    if (busy !== 1'b0 || led !== 8'h00) begin
      bad++;
      $display("FAIL start_back_same: busy=%0b led=%h, want 0 00", busy, led);
    end
    start = 1'b0;
    back  = 1'b0;
    cyc(2);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || score !== 8'd1) begin
      bad++;
      $display("FAIL stay_idle: busy=%0b done=%0b score=%0d, want 0 0 1", busy, done, score);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL back_pending: %0d pulses never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    start_song();
    goto_pos(3);
    #2;
    RESETN = 1'b0;
    #1;
    total++;
    if ({led, tone_req, tone_sel, hit_pulse, miss_pulse, score, combo, busy, done} !== 39'h0) begin
      bad++;
      $display("FAIL async_reset: led=%h tone=%0b busy=%0b done=%0b, want all 0", led, tone_req, busy, done);
    end
    cyc(2);
    RESETN = 1'b1;
    cyc(3);
    total++;
    if (busy !== 1'b0 || led !== 8'h00 || score !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%0b led=%h score=%0d, want 0 00 0", busy, led, score);
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_chord_hit();
    test_chord_late();
    test_wrong_key();
    test_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
